// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with 2-flop input synchronizer, oversampled
// bit timing and 3-sample majority-vote bit decisions. A received byte is
// offered on a valid/ack handshake. Framing errors pulse frame_err_o, and a
// byte that lands on an unconsumed one sets the sticky overrun_o flag.
// Optional build macro UART_RX_PARITY_EN switches to 8E1 framing and adds
// the parity_err_o pulse output.
module uart_rx #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       uart_txd_i,
    output logic [7:0] byte_o,
    output logic       valid_o,
    input  logic       ack_i,
    output logic       frame_err_o,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err_o,
`endif
    output logic       overrun_o
);

    // Clock cycles per oversample tick; must be at least 2.
    localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int S_W   = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [S_W-1:0]   S_LAST   = S_W'(OVERSAMPLE - 1);
    // The third of the three centre samples; the vote is taken right after it.
    localparam logic [S_W-1:0]   S_DECIDE = S_W'(OVERSAMPLE / 2 + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t           state_q;
    state_t           state_d;

    logic [1:0]       sync_q;
    logic             line;
    logic             line_q;
    logic [2:0]       samp_q;
    logic [DIV_W-1:0] div_cnt;
    logic [S_W-1:0]   s_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_q;
    logic             decide_q;

    logic             tick;
    logic             s_wrap;
    logic             bit_val;
    logic             stop_decide;

    assign line        = sync_q[1];
    assign tick        = (div_cnt == DIV_LAST);
    assign s_wrap      = tick && (s_cnt == S_LAST);
    assign bit_val     = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) |
                         (samp_q[1] & samp_q[2]);
    assign stop_decide = (state_q == ST_STOP) && decide_q;

    // Bring the asynchronous serial line into the clock domain; idle level is 1.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 2'b11;
            line_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every flop here see the
            // pre-edge values, so the two stages really are two stages.
            sync_q <= {sync_q[0], uart_txd_i};
            line_q <= line;
        end
    end

    // Oversample tick divider, sample index and the 3-deep sample window.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt  <= '0;
            s_cnt    <= '0;
            decide_q <= 1'b0;
            samp_q   <= 3'b111;
        end else begin
            if (tick) begin
                samp_q <= {samp_q[1:0], line};
            end
            if (state_q == ST_IDLE || state_q == ST_BREAK) begin
                // Held at zero so the first tick lands DIV cycles after the start edge.
                div_cnt  <= '0;
                s_cnt    <= '0;
                decide_q <= 1'b0;
            end else begin
                div_cnt  <= tick ? '0 : div_cnt + 1'b1;
                decide_q <= tick && (s_cnt == S_DECIDE);
                if (tick) begin
                    s_cnt <= (s_cnt == S_LAST) ? '0 : s_cnt + 1'b1;
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic: frame sequencing driven by ticks and bit decisions.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (line_q && !line) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (decide_q && bit_val) begin
                    state_d = ST_IDLE;
                end else if (s_wrap) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (s_wrap && bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = ST_STOP;
`endif
                end
            end
            ST_PARITY: begin
                if (s_wrap) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (decide_q) begin
                    state_d = bit_val ? ST_IDLE : ST_BREAK;
                end
            end
            ST_BREAK: begin
                if (line) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Data bit counter and LSB-first shift register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bit_cnt <= '0;
            shift_q <= '0;
        end else begin
            if (state_q == ST_START) begin
                bit_cnt <= '0;
            end else if (state_q == ST_DATA && s_wrap) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (state_q == ST_DATA && decide_q) begin
                shift_q <= {bit_val, shift_q[7:1]};
            end
        end
    end

    // Consumer handshake, overrun tracking and error pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            byte_o      <= '0;
            valid_o     <= 1'b0;
            overrun_o   <= 1'b0;
            frame_err_o <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_o <= 1'b0;
`endif
        end else begin
            frame_err_o <= stop_decide && !bit_val;
`ifdef UART_RX_PARITY_EN
            parity_err_o <= (state_q == ST_PARITY) && decide_q && (bit_val != ^shift_q);
`endif
            if (stop_decide && bit_val) begin
                byte_o  <= shift_q;
                valid_o <= 1'b1;
                // An ack in the same cycle consumes the old byte: no overrun.
                if (valid_o) begin
                    overrun_o <= !ack_i;
                end
            end else if (valid_o && ack_i) begin
                valid_o   <= 1'b0;
                overrun_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed plus randomized stimulus for uart_rx at
// CLK_FREQ=1.6 MHz, BAUD=10 kbit/s (160 clk per bit). Expected bytes come
// from a queue of what was transmitted; flags from frame-level rules.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CLK_FREQ   = 1600000;
    localparam int BAUD       = 10000;
    localparam int OVERSAMPLE = 16;
    localparam int BIT_CLK    = CLK_FREQ / BAUD;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       txd = 1'b1;
    logic       ack = 1'b0;
    logic [7:0] byte_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       overrun_o;
`ifdef UART_RX_PARITY_EN
    logic       parity_err_o;
`endif

    int total = 0;
    int bad   = 0;

    int cyc = 0;
    int rise_cyc = 0;
    int start_cyc = 0;
    int fe_cnt = 0;
    int pe_cnt = 0;
    logic valid_d = 1'b0;

    logic [7:0] exp_q[$];

    uart_rx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OVERSAMPLE)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .uart_txd_i (txd),
        .byte_o     (byte_o),
        .valid_o    (valid_o),
        .ack_i      (ack),
        .frame_err_o(frame_err_o),
`ifdef UART_RX_PARITY_EN
        .parity_err_o(parity_err_o),
`endif
        .overrun_o  (overrun_o)
    );

    always #5 clk = ~clk;

    // Cycle count, valid rising-edge time and error pulse counters.
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        valid_d <= valid_o;
        if (valid_o && !valid_d) rise_cyc <= cyc;
        if (frame_err_o) fe_cnt <= fe_cnt + 1;
`ifdef UART_RX_PARITY_EN
        if (parity_err_o) pe_cnt <= pe_cnt + 1;
`endif
    end

    // Hard stop if anything stalls.
    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Transmit one frame: start, 8 data bits LSB first, [even parity], stop.
    // Optional 5-clk inverted spike at each bit centre.
    task automatic send_frame(input logic [7:0] data, input int bit_clk,
                              input logic stop_val, input logic par_flip,
                              input logic spikes);
        logic [10:0] bits;
        logic        par;
        int          n;
        par       = (^data) ^ par_flip;
        bits[0]   = 1'b0;
        bits[8:1] = data;
`ifdef UART_RX_PARITY_EN
        bits[9]  = par;
        bits[10] = stop_val;
        n = 11;
`else
        bits[9]  = stop_val;
        bits[10] = par;
        n = 10;
`endif
        start_cyc = cyc;
        for (int b = 0; b < n; b++) begin
            txd = bits[b];
            if (spikes) begin
                repeat (bit_clk / 2 - 2) @(negedge clk);
                txd = ~bits[b];
                repeat (5) @(negedge clk);
                txd = bits[b];
                repeat (bit_clk - bit_clk / 2 - 3) @(negedge clk);
            end else begin
                repeat (bit_clk) @(negedge clk);
            end
        end
        txd = 1'b1;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Receive a good frame and check it against the model queue, then ack.
    task automatic rx_and_ack(input string tag, input logic [7:0] d,
                              input int bit_clk, input logic spikes);
        exp_q.push_back(d);
        send_frame(d, bit_clk, 1'b1, 1'b0, spikes);
        idle(20);
        check({tag, "_valid"}, valid_o, 1'b1);
        check({tag, "_byte"}, byte_o, exp_q.pop_front());
        do_ack();
        check({tag, "_ack_clears"}, valid_o, 1'b0);
    endtask

    initial begin
        int fe0;
        int lat;
        logic [7:0] d;

        // Reset values
        idle(3);
        check("rst_byte", byte_o, 8'h00);
        check("rst_valid", valid_o, 1'b0);
        check("rst_frame_err", frame_err_o, 1'b0);
        check("rst_overrun", overrun_o, 1'b0);
        rst_n = 1'b1;
        idle(10);

        // ack with nothing pending is ignored
        do_ack();
        check("ack_idle_valid", valid_o, 1'b0);

        // 1. 0xA5 with latency window
        send_frame(8'hA5, BIT_CLK, 1'b1, 1'b0, 1'b0);
        idle(20);
        lat = rise_cyc - start_cyc;
        check("a5_latency_window", (lat >= 1500 && lat <= 1580), 1'b1);
        check("a5_valid", valid_o, 1'b1);
        check("a5_byte", byte_o, 8'hA5);
        check("a5_no_overrun", overrun_o, 1'b0);
        do_ack();
        check("a5_ack_clears", valid_o, 1'b0);

        // 2. 40-clk glitch on the idle line
        fe0 = fe_cnt;
        txd = 1'b0;
        idle(40);
        txd = 1'b1;
        idle(2000);
        check("glitch_no_valid", valid_o, 1'b0);
        check("glitch_no_frame_err", fe_cnt, fe0);

        // 3. Framing error then recovery
        fe0 = fe_cnt;
        send_frame(8'h3C, BIT_CLK, 1'b0, 1'b0, 1'b0);
        idle(40);
        check("ferr_one_pulse", fe_cnt, fe0 + 1);
        check("ferr_no_valid", valid_o, 1'b0);
        rx_and_ack("after_ferr_81", 8'h81, BIT_CLK, 1'b0);

        // Random bytes against the queue model
        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom);
            rx_and_ack("rand", d, BIT_CLK, 1'b0);
        end

        // 4. Overrun
        send_frame(8'h11, BIT_CLK, 1'b1, 1'b0, 1'b0);
        idle(20);
        check("ovr_first_no_flag", overrun_o, 1'b0);
        send_frame(8'h22, BIT_CLK, 1'b1, 1'b0, 1'b0);
        idle(20);
        check("ovr_byte", byte_o, 8'h22);
        check("ovr_valid", valid_o, 1'b1);
        check("ovr_flag", overrun_o, 1'b1);
        do_ack();
        check("ovr_ack_valid", valid_o, 1'b0);
        check("ovr_ack_flag", overrun_o, 1'b0);

        // 5. Baud error and bit-centre spikes
        rx_and_ack("slow3_55", 8'h55, BIT_CLK + BIT_CLK * 3 / 100, 1'b1);
        rx_and_ack("fast3_55", 8'h55, BIT_CLK - BIT_CLK * 3 / 100, 1'b1);
        d = 8'($urandom);
        rx_and_ack("spike_rand", d, BIT_CLK, 1'b1);

        // 6. Asynchronous reset mid-frame
        send_frame(8'h99, BIT_CLK, 1'b1, 1'b0, 1'b0);
        idle(20);
        check("pre_rst_valid", valid_o, 1'b1);
        txd = 1'b0;
        idle(500);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", valid_o, 1'b0);
        check("async_rst_byte", byte_o, 8'h00);
        check("async_rst_overrun", overrun_o, 1'b0);
        check("async_rst_frame_err", frame_err_o, 1'b0);
        @(negedge clk);
        txd = 1'b1;
        idle(5);
        rst_n = 1'b1;
        idle(1200);
        check("no_partial_byte", valid_o, 1'b0);
        rx_and_ack("after_rst_f0", 8'hF0, BIT_CLK, 1'b0);

`ifdef UART_RX_PARITY_EN
        // Parity mismatch still delivers the byte
        check("parity_none_yet", pe_cnt, 0);
        send_frame(8'h07, BIT_CLK, 1'b1, 1'b1, 1'b0);
        idle(20);
        check("parity_err_pulse", pe_cnt, 1);
        check("parity_valid", valid_o, 1'b1);
        check("parity_byte", byte_o, 8'h07);
        do_ack();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
